// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//   MM:SS stopwatch controller with run/pause, clear and a two-field manual
//   adjust mode. All outputs are registered and sent to a display multiplexer.
//
// Ports
//   clk                  system clock, rising edge
//   rst_n                asynchronous active-low reset
//   tick_1hz             one-cycle count enable
//   tick_blink           one-cycle blink enable
//   btn_go               start/pause pulse
//   btn_clr              clear pulse (highest priority)
//   btn_adj              adjust-select pulse
//   btn_inc              adjust-increment pulse
//   min_tens..sec_ones   BCD digits
//   blank[3:0]           per-digit blanking, bit3=min_tens .. bit0=sec_ones
//   mode[1:0]            0=IDLE 1=RUN 2=PAUSE 3=ADJ_MIN/ADJ_SEC
//   wrap                 one-cycle pulse on rollover from max to 00:00
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int MAX_MIN_TENS = 5,
  parameter int MAX_SEC_TENS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_blink,
  input  logic       btn_go,
  input  logic       btn_clr,
  input  logic       btn_adj,
  input  logic       btn_inc,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] blank,
  output logic [1:0] mode,
  output logic       wrap
);

  localparam logic [3:0] MIN_TENS_MAX = 4'(MAX_MIN_TENS);
  localparam logic [3:0] SEC_TENS_MAX = 4'(MAX_SEC_TENS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PAUSE   = 3'd2,
    ADJ_MIN = 3'd3,
    ADJ_SEC = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] blank_q, blank_d;
  logic [1:0] mode_q, mode_d;
  logic       wrap_q, wrap_d;
  logic       blink_q, blink_d;

  // Each field is at its top value (x9 with tens at its maximum); incrementing
  // from there returns that field to 00.
  logic sec_at_max, min_at_max;
  assign sec_at_max = (sec_tens_q == SEC_TENS_MAX) && (sec_ones_q == 4'd9);
  assign min_at_max = (min_tens_q == MIN_TENS_MAX) && (min_ones_q == 4'd9);

  // Field-increment helpers, shared by counting and adjusting.
  logic [3:0] sec_tens_inc, sec_ones_inc, min_tens_inc, min_ones_inc;
  logic       sec_carry;

  always_comb begin
    sec_carry    = 1'b0;
    sec_ones_inc = sec_ones_q + 4'd1;
    sec_tens_inc = sec_tens_q;
    if (sec_ones_q == 4'd9) begin
      sec_ones_inc = 4'd0;
      if (sec_tens_q == SEC_TENS_MAX) begin
        sec_tens_inc = 4'd0;
        sec_carry    = 1'b1;
      end else begin
        sec_tens_inc = sec_tens_q + 4'd1;
      end
    end

    min_ones_inc = min_ones_q + 4'd1;
    min_tens_inc = min_tens_q;
    if (min_ones_q == 4'd9) begin
      min_ones_inc = 4'd0;
      min_tens_inc = (min_tens_q == MIN_TENS_MAX) ? 4'd0 : min_tens_q + 4'd1;
    end
  end

  // Next-state, next-digit and registered-output logic.
  always_comb begin
    state_d    = state_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    wrap_d     = 1'b0;
    blink_d    = blink_q ^ tick_blink;

    if (btn_clr) begin
      // Clear swallows every other input this cycle, including tick_blink.
      state_d    = IDLE;
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
      blink_d    = blink_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_go)       state_d = RUN;
          else if (btn_adj) state_d = ADJ_MIN;
        end
        RUN: begin
          // A tick coinciding with btn_go is still counted before pausing.
          if (tick_1hz) begin
            sec_tens_d = sec_tens_inc;
            sec_ones_d = sec_ones_inc;
            if (sec_carry) begin
              min_tens_d = min_tens_inc;
              min_ones_d = min_ones_inc;
            end
            wrap_d = sec_at_max && min_at_max;
          end
          if (btn_go) state_d = PAUSE;
        end
        PAUSE: begin
          if (btn_go)       state_d = RUN;
          else if (btn_adj) state_d = ADJ_MIN;
        end
        ADJ_MIN: begin
          if (btn_inc) begin
            min_tens_d = min_tens_inc;
            min_ones_d = min_ones_inc;
          end
          // btn_go has no action here but still suppresses a same-cycle btn_adj.
          if (btn_adj && !btn_go) state_d = ADJ_SEC;
        end
        ADJ_SEC: begin
          // Seconds wrap within their own field; no carry into minutes.
          if (btn_inc) begin
            sec_tens_d = sec_tens_inc;
            sec_ones_d = sec_ones_inc;
          end
          if (btn_adj && !btn_go) state_d = PAUSE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Blinking always starts from the lit phase when a field is selected.
    if ((state_d == ADJ_MIN || state_d == ADJ_SEC) && state_d != state_q)
      blink_d = 1'b0;

    // blank and mode are derived from the next state so they change on the
    // same edge as the state register.
    blank_d = 4'b0000;
    mode_d  = 2'd0;
    case (state_d)
      RUN:     mode_d = 2'd1;
      PAUSE:   mode_d = 2'd2;
      ADJ_MIN: begin
        mode_d  = 2'd3;
        blank_d = {{2{blink_d}}, 2'b00};
      end
      ADJ_SEC: begin
        mode_d  = 2'd3;
        blank_d = {2'b00, {2{blink_d}}};
      end
      default: mode_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      blank_q    <= 4'b0000;
      mode_q     <= 2'd0;
      wrap_q     <= 1'b0;
      blink_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      blank_q    <= blank_d;
      mode_q     <= mode_d;
      wrap_q     <= wrap_d;
      blink_q    <= blink_d;
    end
  end

  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign blank    = blank_q;
  assign mode     = mode_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Directed self-checking bench for stopwatch_ctrl with default parameters
//   (range 00:00..59:59). Digits are compared as a packed BCD word MMSS.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       tick_blink = 1'b0;
  logic       btn_go = 1'b0;
  logic       btn_clr = 1'b0;
  logic       btn_adj = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [3:0] blank;
  logic [1:0] mode;
  logic       wrap;

  int checks = 0;
  int failures = 0;

  stopwatch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_1hz   (tick_1hz),
    .tick_blink (tick_blink),
    .btn_go     (btn_go),
    .btn_clr    (btn_clr),
    .btn_adj    (btn_adj),
    .btn_inc    (btn_inc),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .blank      (blank),
    .mode       (mode),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  logic [15:0] digits;
  assign digits = {min_tens, min_ones, sec_tens, sec_ones};

  // One clock of stimulus: inputs set at the falling edge, held through the
  // rising edge, outputs settle by #1 after it, then inputs are released.
  task automatic cyc(input logic go, input logic clr, input logic adj,
                     input logic inc, input logic tick, input logic blink);
    @(negedge clk);
    btn_go = go; btn_clr = clr; btn_adj = adj; btn_inc = inc;
    tick_1hz = tick; tick_blink = blink;
    @(posedge clk);
    #1;
    btn_go = 0; btn_clr = 0; btn_adj = 0; btn_inc = 0;
    tick_1hz = 0; tick_blink = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({digits, blank, mode, wrap} !== 23'd0) begin
      failures++;
      $display("FAIL reset_state: got digits=%h blank=%b mode=%0d wrap=%b, want all 0",
               digits, blank, mode, wrap);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // First edge after reset honours inputs.
    cyc(1, 0, 0, 0, 0, 0);
    checks++;
    if (mode !== 2'd1) begin
      failures++;
      $display("FAIL reset_first_edge: mode=%0d want 1", mode);
    end
    cyc(0, 1, 0, 0, 0, 0);
    $display("test_reset done");
  endtask

  task automatic test_count;
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    checks++;
    if (digits !== 16'h0001) begin
      failures++;
      $display("FAIL count_first_tick: digits=%h want 0001", digits);
    end
    for (int i = 0; i < 74; i++) cyc(0, 0, 0, 0, 1, 0);
    checks++;
    if (digits !== 16'h0115 || mode !== 2'd1 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL count_75: digits=%h mode=%0d wrap=%b want 0115 1 0", digits, mode, wrap);
    end
    // btn_adj ignored in RUN
    cyc(0, 0, 1, 0, 0, 0);
    checks++;
    if (mode !== 2'd1) begin
      failures++;
      $display("FAIL adj_in_run: mode=%0d want 1", mode);
    end
    $display("test_count done");
  endtask

  task automatic test_wrap;
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    // Minutes wrap modulo 60 within the field, no wrap pulse.
    for (int i = 0; i < 60; i++) begin
      cyc(0, 0, 0, 1, 0, 0);
      if (wrap !== 1'b0) begin
        checks++; failures++;
        $display("FAIL inc_min_wrap_pulse: wrap=%b at inc %0d want 0", wrap, i);
      end
    end
    checks++;
    if (digits !== 16'h0000 || mode !== 2'd3) begin
      failures++;
      $display("FAIL min_modulo: digits=%h mode=%0d want 0000 3", digits, mode);
    end
    for (int i = 0; i < 59; i++) cyc(0, 0, 0, 1, 0, 0);
    checks++;
    if (digits !== 16'h5900) begin
      failures++;
      $display("FAIL preload_min: digits=%h want 5900", digits);
    end
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 58; i++) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    checks++;
    if (digits !== 16'h5958 || mode !== 2'd2) begin
      failures++;
      $display("FAIL preload_5958: digits=%h mode=%0d want 5958 2", digits, mode);
    end
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    checks++;
    if (digits !== 16'h5959 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL tick_to_5959: digits=%h wrap=%b want 5959 0", digits, wrap);
    end
    cyc(0, 0, 0, 0, 1, 0);
    checks++;
    if (digits !== 16'h0000 || wrap !== 1'b1 || mode !== 2'd1) begin
      failures++;
      $display("FAIL rollover: digits=%h wrap=%b mode=%0d want 0000 1 1", digits, wrap, mode);
    end
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (wrap !== 1'b0) begin
      failures++;
      $display("FAIL wrap_one_cycle: wrap=%b want 0", wrap);
    end
    cyc(0, 0, 0, 0, 1, 0);
    checks++;
    if (digits !== 16'h0001) begin
      failures++;
      $display("FAIL count_after_wrap: digits=%h want 0001", digits);
    end
    $display("test_wrap done");
  endtask

  task automatic test_coincide;
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    checks++;
    if (digits !== 16'h0010 || mode !== 2'd2) begin
      failures++;
      $display("FAIL go_tick_run: digits=%h mode=%0d want 0010 2", digits, mode);
    end
    cyc(0, 0, 0, 0, 1, 0);
    checks++;
    if (digits !== 16'h0010) begin
      failures++;
      $display("FAIL tick_in_pause: digits=%h want 0010", digits);
    end
    cyc(1, 0, 0, 0, 1, 0);
    checks++;
    if (digits !== 16'h0010 || mode !== 2'd1) begin
      failures++;
      $display("FAIL go_tick_pause: digits=%h mode=%0d want 0010 1", digits, mode);
    end
    $display("test_coincide done");
  endtask

  task automatic test_adjust;
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    checks++;
    if (mode !== 2'd3 || blank !== 4'b0000) begin
      failures++;
      $display("FAIL enter_adj_min: mode=%0d blank=%b want 3 0000", mode, blank);
    end
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (blank !== 4'b1100) begin
      failures++;
      $display("FAIL blink_min_on: blank=%b want 1100", blank);
    end
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (blank !== 4'b0000) begin
      failures++;
      $display("FAIL blink_min_off: blank=%b want 0000", blank);
    end
    cyc(0, 0, 0, 0, 0, 1);   // phase 1 again before leaving
    cyc(0, 0, 0, 0, 1, 0);   // tick ignored in adjust
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
    checks++;
    if (digits !== 16'h0300 || blank !== 4'b1100) begin
      failures++;
      $display("FAIL adj_min_inc3: digits=%h blank=%b want 0300 1100", digits, blank);
    end
    cyc(0, 0, 1, 0, 0, 0);
    checks++;
    if (mode !== 2'd3 || blank !== 4'b0000) begin
      failures++;
      $display("FAIL enter_adj_sec: mode=%0d blank=%b want 3 0000", mode, blank);
    end
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (blank !== 4'b0011) begin
      failures++;
      $display("FAIL blink_sec_on: blank=%b want 0011", blank);
    end
    cyc(1, 0, 0, 0, 0, 0);   // go ignored in adjust
    checks++;
    if (mode !== 2'd3) begin
      failures++;
      $display("FAIL go_in_adj: mode=%0d want 3", mode);
    end
    for (int i = 0; i < 61; i++) begin
      cyc(0, 0, 0, 1, 0, 0);
      if (wrap !== 1'b0 || min_ones !== 4'd3) begin
        checks++; failures++;
        $display("FAIL adj_sec_nocarry: wrap=%b min=%h%h at inc %0d want 0 03",
                 wrap, min_tens, min_ones, i);
      end
    end
    cyc(0, 0, 1, 0, 0, 0);
    checks++;
    if (digits !== 16'h0301 || mode !== 2'd2 || blank !== 4'b0000) begin
      failures++;
      $display("FAIL adj_exit: digits=%h mode=%0d blank=%b want 0301 2 0000", digits, mode, blank);
    end
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (blank !== 4'b0000) begin
      failures++;
      $display("FAIL blink_in_pause: blank=%b want 0000", blank);
    end
    cyc(0, 0, 0, 1, 0, 0);
    checks++;
    if (digits !== 16'h0301) begin
      failures++;
      $display("FAIL inc_in_pause: digits=%h want 0301", digits);
    end
    $display("test_adjust done");
  endtask

  task automatic test_clear;
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 34; i++) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    checks++;
    if (digits !== 16'h1234 || mode !== 2'd1) begin
      failures++;
      $display("FAIL run_1234: digits=%h mode=%0d want 1234 1", digits, mode);
    end
    cyc(1, 1, 1, 1, 1, 0);
    checks++;
    if (digits !== 16'h0000 || mode !== 2'd0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL clr_priority: digits=%h mode=%0d wrap=%b want 0000 0 0", digits, mode, wrap);
    end
    // go beats adj in IDLE
    cyc(1, 0, 1, 0, 0, 0);
    checks++;
    if (mode !== 2'd1) begin
      failures++;
      $display("FAIL go_beats_adj: mode=%0d want 1", mode);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
    // Asynchronous reset between edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({digits, blank, mode, wrap} !== 23'd0) begin
      failures++;
      $display("FAIL async_reset: digits=%h blank=%b mode=%0d wrap=%b want all 0",
               digits, blank, mode, wrap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 1, 0);
    checks++;
    if (digits !== 16'h0000 || mode !== 2'd0) begin
      failures++;
      $display("FAIL after_reset_idle: digits=%h mode=%0d want 0000 0", digits, mode);
    end
    $display("test_clear done");
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_coincide();
    test_adjust();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time bound so the run can never hang.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL expose parameter MAX_MIN_TENS, default 5, meaning the highest legal minutes-tens digit; the counted range is 00:00 to (MAX_MIN_TENS)9:59.
REQ-002 The block SHALL expose parameter MAX_SEC_TENS, default 5, meaning the highest legal seconds-tens digit.
REQ-003 clk  input  1  system clock; all state changes occur on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 tick_1hz  input  1  single-cycle count enable, synchronous to clk.
REQ-006 tick_blink  input  1  single-cycle blink enable, synchronous to clk.
REQ-007 btn_go  input  1  debounced single-cycle start/pause pulse.
REQ-008 btn_clr  input  1  debounced single-cycle clear pulse.
REQ-009 btn_adj  input  1  debounced single-cycle adjust-select pulse.
REQ-010 btn_inc  input  1  debounced single-cycle adjust-increment pulse.
REQ-011 min_tens, min_ones, sec_tens, sec_ones  output  4 each  registered BCD digits, fed to the display multiplexer.
REQ-012 blank  output  4  per-digit blanking; bit3=min_tens through bit0=sec_ones; 1 means the digit is dark.
REQ-013 mode  output  2  current state: 0=IDLE, 1=RUN, 2=PAUSE, 3=ADJ (ADJ_MIN or ADJ_SEC).
REQ-014 wrap  output  1  registered one-cycle pulse on rollover from maximum to 00:00.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN, PAUSE, ADJ_MIN and ADJ_SEC.
REQ-016 btn_clr SHALL have the highest priority: from any state it goes to IDLE and sets all digits to 0 on the next edge, and every other input in that cycle is ignored.
REQ-017 btn_go SHALL move IDLE->RUN, RUN->PAUSE and PAUSE->RUN, and SHALL be ignored in ADJ_MIN and ADJ_SEC.
REQ-018 btn_adj SHALL move IDLE->ADJ_MIN, PAUSE->ADJ_MIN, ADJ_MIN->ADJ_SEC and ADJ_SEC->PAUSE, and SHALL be ignored in RUN.
REQ-019 When btn_go and btn_adj are asserted in the same cycle, btn_go SHALL win and btn_adj SHALL be dropped.
REQ-020 Counting: only in RUN, one tick_1hz increments the time by one second, and the digits reflect it on the edge following the tick (1-cycle latency).
REQ-021 BCD arithmetic: sec_ones 9->0 carries into sec_tens; sec_tens MAX_SEC_TENS with sec_ones 9 ->0 carries into min_ones; min_ones 9->0 carries into min_tens; no digit ever holds a value above 9, and no tens digit exceeds its MAX parameter.
REQ-022 At the maximum time (for example 59:59), a tick in RUN SHALL produce 00:00 and wrap=1 for exactly one cycle; counting SHALL continue.
REQ-023 If tick_1hz and btn_go coincide in RUN, the tick SHALL be counted and the next state SHALL be PAUSE.
REQ-024 If tick_1hz and btn_go coincide in PAUSE, the next state SHALL be RUN and the tick SHALL NOT be counted.
REQ-025 tick_1hz SHALL be ignored in IDLE, PAUSE, ADJ_MIN and ADJ_SEC.
REQ-026 btn_inc in ADJ_MIN SHALL increment the minutes field modulo (MAX_MIN_TENS+1)*10, leaving the seconds unchanged; btn_inc in ADJ_SEC SHALL increment the seconds field modulo 60, with no carry into the minutes.
REQ-027 btn_inc SHALL be ignored outside ADJ_MIN and ADJ_SEC; wrap SHALL never assert because of btn_inc.
REQ-028 An internal blink_phase SHALL toggle on each tick_blink and be forced to 0 on entry to ADJ_MIN or ADJ_SEC.
REQ-029 blank SHALL be 4'b0000 except: in ADJ_MIN, blank[3:2]={2{blink_phase}}; in ADJ_SEC, blank[1:0]={2{blink_phase}}.
REQ-030 blank and mode SHALL be registered outputs that update on the same edge as the state change.

Reset
REQ-031 While rst_n=0, the block SHALL immediately and asynchronously force: state IDLE, all digits 0, blank 4'b0000, mode 0, wrap 0, blink_phase 0.
REQ-032 Reset asserted mid-count or mid-adjust SHALL discard the time in progress, with no residual wrap pulse.
REQ-033 After rst_n rises, the first edge SHALL honour the inputs normally.

Verification
REQ-034 Reset, then btn_go, then 75 ticks -> digits 01:15, mode=1.
REQ-035 Preload to 59:58 via adjust, btn_go, then 2 ticks -> 59:59, then 00:00 with wrap high for exactly one cycle.
REQ-036 In RUN at 00:09, btn_go and tick in the same cycle -> 00:10, mode=2; then btn_go and tick in the same cycle -> still 00:10, mode=1.
REQ-037 From IDLE: btn_adj, 3x btn_inc, btn_adj, 61x btn_inc, btn_adj -> 03:01, mode=2; blank[3:2] toggles with tick_blink only in ADJ_MIN.
REQ-038 btn_clr together with btn_go in RUN at 12:34 -> 00:00, mode=0; rst_n pulsed low mid-RUN -> all outputs 0 asynchronously.
